fifo_read_scheduler: RTL and testbench

- Shares one FIFO_Reader_Helper byte serializer between N_CH word FIFOs, each paired with an RCC buffer length.
- Arbitrates pending channel requests round-robin and issues one helper read transaction per grant.
- Steers the granted FIFO's dout/empty/rd_en through the helper, tracks word pops to detect completion, and returns a per-channel done pulse.
- Sits between the RCC channel buffers and the single serializer feeding the byte stream.

---
 rtl/fifo_read_scheduler_pkg.sv | 17 +
 rtl/fifo_read_scheduler_rr_arbiter.sv | 31 +++
 rtl/fifo_read_scheduler.sv | 159 +++++++++++++++
 tb/tb_fifo_read_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_scheduler_pkg.sv
// Shared types and helpers for the FIFO read scheduler.
package fifo_read_scheduler_pkg;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_RUN,
    SCHED_DONE,
    SCHED_GAP
  } fifo_sched_state;

  // Number of 32-bit words needed to carry len bytes (ceil(len/4)).
  function automatic int unsigned len_to_words(input int unsigned len);
    return (len >> 2) + (((len & 32'd3) != 32'd0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/fifo_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: first eligible channel at or after ptr, wrapping modulo N_CH.
module fifo_read_scheduler_rr_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_CH);
      if (!valid && eligible[cand]) begin
        valid       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_scheduler.sv
// Shares one FIFO-to-byte helper between N_CH word FIFOs. Channels are granted
// round-robin; the granted FIFO is steered to the helper until its words are consumed.
// Optional: define SCHED_PRIO_EN to give channel 0 absolute priority.
module fifo_read_scheduler
  import fifo_read_scheduler_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned LEN_W = 6,
  parameter int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_CH-1:0]       ch_req,
  input  logic [N_CH*LEN_W-1:0] ch_len,
  input  logic [N_CH-1:0]       ch_fifo_empty,
  input  logic [N_CH*32-1:0]    ch_fifo_dout,
  output logic [N_CH-1:0]       ch_fifo_rd_en,
  output logic                  hlp_read_request,
  output logic [LEN_W-1:0]      hlp_buffer_length,
  output logic                  hlp_fifo_empty,
  output logic [31:0]           hlp_fifo_dout,
  input  logic                  hlp_fifo_rd_en,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy,
  output logic [N_CH-1:0]       ch_done
);

  fifo_sched_state  state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] exp_words_q, exp_words_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;

  logic [LEN_W-1:0] len_arr  [N_CH];
  logic [31:0]      dout_arr [N_CH];
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  rr_grant;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_valid;
  logic             win_prio;
  logic [N_CH-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic [LEN_W-1:0] win_len;

  // A zero-length request needs no FIFO data, so it is eligible even when empty.
  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign len_arr[i]  = ch_len[i*LEN_W +: LEN_W];
    assign dout_arr[i] = ch_fifo_dout[i*32 +: 32];
    assign eligible[i] = ch_req[i] & (~ch_fifo_empty[i] | (len_arr[i] == '0));
  end

  fifo_read_scheduler_rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .valid     (rr_valid)
  );

`ifdef SCHED_PRIO_EN
  assign win_prio = eligible[0];
`else
  assign win_prio = 1'b0;
`endif

  assign win_oh  = win_prio ? N_CH'(1) : rr_grant;
  assign win_idx = win_prio ? '0 : rr_idx;

  // One-hot select of the winner's byte length.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (win_oh[i]) win_len = win_len | len_arr[i];
    end
  end

  // Next-state, transfer bookkeeping and steering outputs.
  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    grant_idx_d       = grant_idx_q;
    len_d             = len_q;
    exp_words_d       = exp_words_q;
    word_cnt_d        = word_cnt_q;
    hlp_read_request  = 1'b0;
    hlp_fifo_empty    = 1'b1;
    ch_fifo_rd_en     = '0;
    ch_done           = '0;
    busy              = (state_q != SCHED_IDLE);
    hlp_buffer_length = (state_q == SCHED_IDLE) ? '0 : len_q;
    hlp_fifo_dout     = dout_arr[grant_idx_q];
    grant_idx         = grant_idx_q;

    unique case (state_q)
      SCHED_IDLE: begin
        if (rr_valid) begin
          grant_idx_d = win_idx;
          len_d       = win_len;
          exp_words_d = LEN_W'(len_to_words(32'(win_len)));
          // A priority win leaves the round-robin order untouched.
          if (!win_prio) begin
            rr_ptr_d = (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + IDX_W'(1);
          end
          state_d = (win_len == '0) ? SCHED_DONE : SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: begin
        hlp_read_request = 1'b1;
        hlp_fifo_empty   = ch_fifo_empty[grant_idx_q];
        state_d          = SCHED_RUN;
      end
      SCHED_RUN: begin
        hlp_fifo_empty             = ch_fifo_empty[grant_idx_q];
        ch_fifo_rd_en[grant_idx_q] = hlp_fifo_rd_en;
        if (hlp_fifo_rd_en) begin
          word_cnt_d = word_cnt_q + LEN_W'(1);
          // The helper also quits when it pops against an empty FIFO.
          if ((word_cnt_d == exp_words_q) || ch_fifo_empty[grant_idx_q]) begin
            state_d = SCHED_DONE;
          end
        end
      end
      SCHED_DONE: begin
        ch_done[grant_idx_q] = 1'b1;
        word_cnt_d           = '0;
        state_d              = SCHED_GAP;
      end
      SCHED_GAP: begin
        // Lets the helper settle back to idle before the next issue.
        state_d = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= SCHED_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      len_q       <= '0;
      exp_words_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      len_q       <= len_d;
      exp_words_q <= exp_words_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Randomized scoreboard bench for fifo_read_scheduler with a behavioural helper and FIFO model.
module tb_fifo_read_scheduler;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned LEN_W = 6;
  localparam int unsigned IDX_W = 2;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [N_CH-1:0]       ch_req;
  logic [N_CH*LEN_W-1:0] ch_len;
  logic [N_CH-1:0]       ch_fifo_empty;
  logic [N_CH*32-1:0]    ch_fifo_dout;
  logic [N_CH-1:0]       ch_fifo_rd_en;
  logic                  hlp_read_request;
  logic [LEN_W-1:0]      hlp_buffer_length;
  logic                  hlp_fifo_empty;
  logic [31:0]           hlp_fifo_dout;
  logic                  hlp_fifo_rd_en;
  logic [IDX_W-1:0]      grant_idx;
  logic                  busy;
  logic [N_CH-1:0]       ch_done;

  always #5 CLK = ~CLK;

  fifo_read_scheduler #(
    .N_CH  (N_CH),
    .LEN_W (LEN_W),
    .IDX_W (IDX_W)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .ch_req            (ch_req),
    .ch_len            (ch_len),
    .ch_fifo_empty     (ch_fifo_empty),
    .ch_fifo_dout      (ch_fifo_dout),
    .ch_fifo_rd_en     (ch_fifo_rd_en),
    .hlp_read_request  (hlp_read_request),
    .hlp_buffer_length (hlp_buffer_length),
    .hlp_fifo_empty    (hlp_fifo_empty),
    .hlp_fifo_dout     (hlp_fifo_dout),
    .hlp_fifo_rd_en    (hlp_fifo_rd_en),
    .grant_idx         (grant_idx),
    .busy              (busy),
    .ch_done           (ch_done)
  );

  typedef struct {
    int ch;
    int len;
    int eff;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] fq [N_CH][$];
  int          ref_ptr = 0;
  int          b_len [N_CH];
  int          b_words [N_CH];

  // Driver-side snapshot and helper model state.
  logic [N_CH-1:0]  s_rd, s_done;
  logic             s_req, s_hempty;
  logic [IDX_W-1:0] s_gidx;
  logic [LEN_W-1:0] s_len;
  bit               h_act = 0, h_pulse = 0, rnd_mode = 0, hold = 0;
  int               h_cnt, h_exp, h_timer, n_done = 0, hold_lim = 0;

  // Monitor tracking.
  int m_reqs = 0, m_pulses = 0, m_eff = 0, m_last = 0, last_any = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int words_of(input int len);
    return (len + 3) / 4;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference arbitration: next requester at or after the pointer, channel 0 first if prioritized.
  function automatic int pick(input logic [N_CH-1:0] s);
    int c;
`ifdef SCHED_PRIO_EN
    if (s[0]) return 0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      c = (ref_ptr + k) % N_CH;
      if (s[c]) begin
        ref_ptr = (c + 1) % N_CH;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic upd_fifo();
    for (int i = 0; i < N_CH; i++) begin
      ch_fifo_empty[i]        = (fq[i].size() == 0);
      ch_fifo_dout[i*32 +: 32] = (fq[i].size() > 0) ? fq[i][0] : 32'h0;
    end
  endtask

  // Monitor: compare every DUT event against the head of the expected queue.
  always @(negedge CLK) begin
    exp_t e;
    int   h;
    cyc++;
    if (RESET) begin
      m_reqs = 0; m_pulses = 0; m_eff = 0; last_any = -100;
    end else begin
      if (hlp_read_request) begin
        if (exp_q.size() == 0) chk("unexpected_request", 1, 0);
        else begin
          chk("req_grant_idx", 64'(grant_idx), 64'(exp_q[0].ch));
          chk("req_buffer_length", 64'(hlp_buffer_length), 64'(exp_q[0].len));
          chk("grant_spacing", 64'(cyc - last_any >= 4), 1);
          m_reqs++;
        end
      end
      if (ch_fifo_rd_en != '0) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 64'(ch_fifo_rd_en), 0);
        else begin
          h = exp_q[0].ch;
          chk("pop_steer", 64'(ch_fifo_rd_en), 64'(1) << h);
          chk("pop_empty_steer", 64'(hlp_fifo_empty), 64'(fq[h].size() == 0));
          if (fq[h].size() > 0) begin
            chk("pop_dout", 64'(hlp_fifo_dout), 64'(fq[h][0]));
            m_eff++;
          end
          m_pulses++;
          m_last   = cyc;
          last_any = cyc;
        end
      end
      if (ch_done != '0) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'(ch_done), 0);
        else begin
          e = exp_q.pop_front();
          chk("done_onehot", 64'(ch_done), 64'(1) << e.ch);
          chk("done_data_pops", 64'(m_eff), 64'(e.eff));
          chk("done_req_pulses", 64'(m_reqs), 64'(e.len != 0));
          if (e.len != 0) chk("done_after_last_pop", 64'(cyc - m_last), 1);
          else chk("len0_no_pulses", 64'(m_pulses), 0);
          m_reqs = 0; m_pulses = 0; m_eff = 0;
        end
      end
    end
  end

  // One clock: snapshot DUT outputs mid-cycle, then update FIFO/helper/stimulus after the edge.
  task automatic step();
    @(negedge CLK);
    s_rd = ch_fifo_rd_en; s_done = ch_done; s_req = hlp_read_request;
    s_hempty = hlp_fifo_empty; s_gidx = grant_idx; s_len = hlp_buffer_length;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (s_rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    if (h_pulse) begin
      h_cnt++;
      hlp_fifo_rd_en = 1'b0;
      h_pulse = 0;
      if (h_cnt >= h_exp || s_hempty) h_act = 0;
      else h_timer = 2;
    end else if (h_act) begin
      if (h_timer == 0) begin
        hlp_fifo_rd_en = 1'b1;
        h_pulse = 1;
      end else h_timer--;
    end else if (s_req) begin
      h_act = 1; h_cnt = 0; h_exp = words_of(int'(s_len)); h_timer = 1;
    end
    if (s_req && rnd_mode) begin
      ch_len[int'(s_gidx)*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) ch_req[s_gidx] = 1'b0;
    end
    if (s_done != '0) n_done++;
    if (hold) begin
      if (n_done >= hold_lim) ch_req = '0;
    end else ch_req = ch_req & ~s_done;
    upd_fifo();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    ch_req = '0;
    hlp_fifo_rd_en = 1'b0;
    h_act = 0; h_pulse = 0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic check_reset_vals();
    @(negedge CLK);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_read_request", 64'(hlp_read_request), 0);
    chk("rst_buffer_length", 64'(hlp_buffer_length), 0);
    chk("rst_fifo_empty", 64'(hlp_fifo_empty), 1);
    chk("rst_grant_idx", 64'(grant_idx), 0);
    chk("rst_done", 64'(ch_done), 0);
    chk("rst_rd_en", 64'(ch_fifo_rd_en), 0);
  endtask

  // Load FIFOs and lengths, predict grant order, and raise the requests.
  task automatic load_batch(input logic [N_CH-1:0] set);
    logic [N_CH-1:0] s;
    int              c;
    exp_t            e;
    for (int i = 0; i < N_CH; i++) begin
      if (set[i]) begin
        fq[i].delete();
        for (int w = 0; w < b_words[i]; w++) fq[i].push_back($urandom);
        ch_len[i*LEN_W +: LEN_W] = LEN_W'(b_len[i]);
      end
    end
    upd_fifo();
    s = set;
    while (s != '0) begin
      c = pick(s);
      s[c] = 1'b0;
      e.ch  = c;
      e.len = b_len[c];
      e.eff = (b_len[c] == 0) ? 0 : min2(words_of(b_len[c]), b_words[c]);
      exp_q.push_back(e);
    end
    n_done = 0;
    ch_req = set;
  endtask

  task automatic wait_batch();
    for (int t = 0; t < 3000 && exp_q.size() > 0; t++) step();
    if (exp_q.size() > 0) begin
      chk("batch_timeout", 64'(exp_q.size()), 0);
      do_reset();
    end
    repeat (2) step();
  endtask

  task automatic run_cont(input int k_lim);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      fq[i].delete();
      for (int w = 0; w < 10; w++) fq[i].push_back($urandom);
      ch_len[i*LEN_W +: LEN_W] = LEN_W'(4);
    end
    upd_fifo();
    for (int n = 0; n < k_lim; n++) begin
      e.ch = pick(N_CH'(3)); e.len = 4; e.eff = 1;
      exp_q.push_back(e);
    end
    n_done = 0; hold_lim = k_lim; hold = 1;
    ch_req = N_CH'(3);
    wait_batch();
    hold = 0;
    ch_req = '0;
  endtask

  initial begin
    int pulses;
    logic [N_CH-1:0] set;
    RESET = 1'b1;
    ch_req = '0; ch_len = '0; hlp_fifo_rd_en = 1'b0;
    for (int i = 0; i < N_CH; i++) fq[i].delete();
    fq[0].push_back(32'hA5A5_0001);
    upd_fifo();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_reset_vals();

    // Stray helper pop while idle must not reach any FIFO.
    @(posedge CLK); #1;
    hlp_fifo_rd_en = 1'b1;
    @(negedge CLK);
    chk("stray_rd_en_no_pop", 64'(ch_fifo_rd_en), 0);
    chk("stray_rd_en_idle", 64'(busy), 0);
    @(posedge CLK); #1;
    hlp_fifo_rd_en = 1'b0;

    // ch0, ch2, ch3 with len=4 and one word each.
    for (int i = 0; i < N_CH; i++) begin b_len[i] = 4; b_words[i] = 1; end
    load_batch(4'b1101); wait_batch();
    // ch1 alone, len=6, two words.
    b_len[1] = 6; b_words[1] = 2;
    load_batch(4'b0010); wait_batch();
    // ch2 len=12 but only one word: early stop.
    b_len[2] = 12; b_words[2] = 1;
    load_batch(4'b0100); wait_batch();
    // ch3 len=0: completes without the helper.
    b_len[3] = 0; b_words[3] = 0;
    load_batch(4'b1000); wait_batch();

    // Reset in the middle of a four-word transfer, then restart cleanly.
    b_len[1] = 16; b_words[1] = 4;
    load_batch(4'b0010);
    pulses = 0;
    for (int t = 0; t < 200 && pulses < 2; t++) begin
      step();
      if (s_rd != '0) pulses++;
    end
    chk("mid_run_pulses_seen", 64'(pulses), 2);
    do_reset();
    check_reset_vals();
    repeat (4) step();
    load_batch(4'b0010); wait_batch();

    // ch0 and ch1 requesting continuously.
    run_cont(6);

    // Randomized batches with mid-transfer request drops and length changes.
    rnd_mode = 1;
    for (int b = 0; b < 30; b++) begin
      set = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int i = 0; i < N_CH; i++) begin
        b_len[i]   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
        b_words[i] = (b_len[i] == 0) ? int'($urandom_range(0, 2))
                                     : int'($urandom_range(1, words_of(b_len[i]) + 1));
      end
      load_batch(set); wait_batch();
    end
    rnd_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
